chip_cmd_sequencer: RTL and testbench

//  Downstream pad-side stage between the SoC accelerator port and the external chip pins.

---
 rtl/chip_cmd_sequencer.sv | 164 ++++++++++++++++
 tb/tb_chip_cmd_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/chip_cmd_sequencer.sv
// Pad-side command sequencer: drives chip pads with a setup/pulse/hold sequence, then
// captures synchronised chip data and returns it as a response.
module chip_cmd_sequencer #(
  parameter int unsigned NumArrays   = 4,
  parameter int unsigned AddrWidth   = 5,
  parameter int unsigned SetupCycles = 2,
  parameter int unsigned HoldCycles  = 2,
  parameter int unsigned PulseWidth  = 8
) (
  input  logic                 clk_sys_in,
  input  logic                 rst_sys_in,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [1:0]           req_instr_i,
  input  logic [AddrWidth-1:0] req_col_i,
  input  logic [AddrWidth-1:0] req_row_i,
  input  logic [3:0]           req_ctrl_i,
  input  logic [PulseWidth-1:0] req_plen_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [NumArrays-1:0] rsp_data_o,
  output logic                 busy_o,
  output logic [1:0]           chip_instr_o,
  output logic [AddrWidth-1:0] chip_col_o,
  output logic [AddrWidth-1:0] chip_row_o,
  output logic                 chip_cbl_o,
  output logic                 chip_cblen_o,
  output logic                 chip_csl_o,
  output logic                 chip_cwl_o,
  input  logic [NumArrays-1:0] chip_data_i
);

  localparam int unsigned ShMax   = (SetupCycles > HoldCycles) ? SetupCycles : HoldCycles;
  localparam int unsigned ShWidth = $clog2(ShMax) + 1;
  localparam int unsigned CntW    = (PulseWidth > ShWidth) ? PulseWidth : ShWidth;

  localparam logic [CntW-1:0] SetupLoad   = CntW'(SetupCycles - 1);
  localparam logic [CntW-1:0] HoldLoad    = CntW'(HoldCycles - 1);
  localparam logic [CntW-1:0] CaptureLoad = CntW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StPulse,
    StHold,
    StCapture,
    StResp
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [3:0]            mask_q;
  logic [PulseWidth-1:0] plen_q;
  logic [3:0]            ctrl_q;
  logic                  ready_q;
  logic [NumArrays-1:0]  sync1_q, sync2_q;
  logic [NumArrays-1:0]  rsp_data_q;
  logic                  accept;
  logic                  capture;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i && ready_q) begin
          accept  = 1'b1;
          state_d = StSetup;
          cnt_d   = SetupLoad;
        end
      end
      StSetup: begin
        if (cnt_q == '0) begin
          if (plen_q != '0) begin
            state_d = StPulse;
            cnt_d   = CntW'(plen_q) - CntW'(1);
          end else begin
            state_d = StHold;
            cnt_d   = HoldLoad;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StPulse: begin
        if (cnt_q == '0) begin
          state_d = StHold;
          cnt_d   = HoldLoad;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          state_d = StCapture;
          cnt_d   = CaptureLoad;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StCapture: begin
        if (cnt_q == '0) begin
          state_d = StResp;
          capture = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp: begin
        if (rsp_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_sys_in or negedge rst_sys_in) begin
    if (!rst_sys_in) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      mask_q       <= '0;
      plen_q       <= '0;
      ctrl_q       <= '0;
      ready_q      <= 1'b0;
      sync1_q      <= '0;
      sync2_q      <= '0;
      rsp_data_q   <= '0;
      chip_instr_o <= '0;
      chip_col_o   <= '0;
      chip_row_o   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Ready is registered so it stays low through the first cycle after reset release.
      ready_q <= (state_d == StIdle);
      ctrl_q  <= (state_d == StPulse) ? mask_q : 4'b0000;
      sync1_q <= chip_data_i;
      sync2_q <= sync1_q;
      if (accept) begin
        mask_q       <= req_ctrl_i;
        plen_q       <= req_plen_i;
        chip_instr_o <= req_instr_i;
        chip_col_o   <= req_col_i;
        chip_row_o   <= req_row_i;
      end
      if (capture) begin
        rsp_data_q <= (chip_instr_o == 2'b11) ? '0 : sync2_q;
      end
    end
  end

  assign req_ready_o  = ready_q;
  assign rsp_valid_o  = (state_q == StResp);
  assign rsp_data_o   = rsp_data_q;
  assign busy_o       = (state_q != StIdle);
  assign chip_cbl_o   = ctrl_q[3];
  assign chip_cblen_o = ctrl_q[2];
  assign chip_csl_o   = ctrl_q[1];
  assign chip_cwl_o   = ctrl_q[0];

endmodule

// File: tb/tb_chip_cmd_sequencer.sv
// Directed bench for chip_cmd_sequencer: vector table of commands plus hand sequences for
// reset, backpressure and reset-during-pulse.
module tb_chip_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_instr = '0;
  logic [4:0] req_col = '0;
  logic [4:0] req_row = '0;
  logic [3:0] req_ctrl = '0;
  logic [7:0] req_plen = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [3:0] rsp_data;
  logic       busy;
  logic [1:0] chip_instr;
  logic [4:0] chip_col, chip_row;
  logic       cbl, cblen, csl, cwl;
  logic [3:0] chip_data = 4'hF;

  chip_cmd_sequencer dut (
    .clk_sys_in  (clk),
    .rst_sys_in  (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_instr_i (req_instr),
    .req_col_i   (req_col),
    .req_row_i   (req_row),
    .req_ctrl_i  (req_ctrl),
    .req_plen_i  (req_plen),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .busy_o      (busy),
    .chip_instr_o(chip_instr),
    .chip_col_o  (chip_col),
    .chip_row_o  (chip_row),
    .chip_cbl_o  (cbl),
    .chip_cblen_o(cblen),
    .chip_csl_o  (csl),
    .chip_cwl_o  (cwl),
    .chip_data_i (chip_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [1:0] instr;
    logic [4:0] col;
    logic [4:0] row;
    logic [3:0] ctrl;
    logic [7:0] plen;
    logic [3:0] data;
    int         lat;
    logic [3:0] rdata;
    int         pstart;
    int         plen_obs;
    logic [3:0] pmask;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Waits for ready, handshakes on the next posedge (edge 0), then drives junk fields.
  task automatic issue_cmd(input vec_t v, input string tag);
    int n;
    chip_data = v.data;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, " ready_before_cmd"}, 64'(req_ready), 64'd1);
    req_instr = v.instr;
    req_col   = v.col;
    req_row   = v.row;
    req_ctrl  = v.ctrl;
    req_plen  = v.plen;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_instr = ~v.instr;
    req_col   = ~v.col;
    req_row   = ~v.row;
    req_ctrl  = ~v.ctrl;
    req_plen  = ~v.plen;
  endtask

  // Counts cycles after the handshake until rsp_valid, recording the ctrl pulse.
  task automatic watch(output int lat, output int pstart, output int pcnt, output int plast,
                       output logic [3:0] mask, output bit bad);
    logic [3:0] c;
    lat = 0; pstart = 0; pcnt = 0; plast = 0; mask = '0; bad = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      c = {cbl, cblen, csl, cwl};
      if (c != 4'b0000) begin
        if (pcnt == 0) begin
          pstart = k;
          mask   = c;
        end else if (c != mask) begin
          bad = 1'b1;
        end
        pcnt++;
        plast = k;
      end
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic rsp_handshake(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check({tag, " post_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, " post_rsp_ready"}, 64'(req_ready), 64'd1);
    check({tag, " post_rsp_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat, pstart, pcnt, plast;
    logic [3:0] mask;
    bit bad;
    issue_cmd(v, tag);
    watch(lat, pstart, pcnt, plast, mask, bad);
    check({tag, " latency"}, 64'(lat), 64'(v.lat));
    check({tag, " rsp_data"}, 64'(rsp_data), 64'(v.rdata));
    check({tag, " pulse_start"}, 64'(pstart), 64'(v.pstart));
    check({tag, " pulse_len"}, 64'(pcnt), 64'(v.plen_obs));
    check({tag, " pulse_mask"}, 64'(mask), 64'(v.pmask));
    check({tag, " pulse_steady"}, 64'(bad), 64'd0);
    if (pcnt != 0) check({tag, " pulse_contig"}, 64'(plast - pstart + 1), 64'(v.plen_obs));
    check({tag, " pads"}, 64'({chip_instr, chip_col, chip_row}),
          64'({v.instr, v.col, v.row}));
    check({tag, " busy"}, 64'(busy), 64'd1);
    rsp_handshake(tag);
  endtask

  initial begin
    vec_t b, b2;
    int lat, pstart, pcnt, plast, nrsp;
    logic [3:0] mask;
    bit bad;

    //           instr  col    row    ctrl     plen   data     lat  rdata    ps  pl   pmask
    vecs[0] = '{2'b11, 5'd5,  5'd17, 4'b1001, 8'd4,   4'b1111, 11,  4'b0000, 3,  4,   4'b1001};
    vecs[1] = '{2'b10, 5'd3,  5'd9,  4'b0110, 8'd0,   4'b1010, 7,   4'b1010, 0,  0,   4'b0000};
    vecs[2] = '{2'b01, 5'd31, 5'd0,  4'b1111, 8'd1,   4'b0101, 8,   4'b0101, 3,  1,   4'b1111};
    vecs[3] = '{2'b00, 5'd7,  5'd7,  4'b0100, 8'd3,   4'b0011, 10,  4'b0011, 3,  3,   4'b0100};
    vecs[4] = '{2'b10, 5'd0,  5'd31, 4'b1111, 8'd0,   4'b1100, 7,   4'b1100, 0,  0,   4'b0000};
    vecs[5] = '{2'b01, 5'd21, 5'd10, 4'b0010, 8'd255, 4'b0111, 262, 4'b0111, 3,  255, 4'b0010};

    // Reset with chip data driven high: every output must be 0.
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({req_ready, rsp_valid, rsp_data, busy, chip_instr, chip_col,
                               chip_row, cbl, cblen, csl, cwl}), 64'd0);
    rst_n = 1'b1;
    #1;
    check("release_ready_before_edge", 64'(req_ready), 64'd0);
    @(negedge clk);
    check("release_ready_next_cycle", 64'(req_ready), 64'd1);
    check("release_busy", 64'(busy), 64'd0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: response held 20 cycles while a new request waits.
    b  = '{2'b10, 5'd12, 5'd3, 4'b1000, 8'd2, 4'b0110, 9, 4'b0110, 3, 2, 4'b1000};
    b2 = '{2'b01, 5'd25, 5'd14, 4'b0001, 8'd1, 4'b1001, 8, 4'b1001, 3, 1, 4'b0001};
    issue_cmd(b, "bp");
    watch(lat, pstart, pcnt, plast, mask, bad);
    check("bp latency", 64'(lat), 64'd9);
    req_instr = b2.instr; req_col = b2.col; req_row = b2.row;
    req_ctrl = b2.ctrl; req_plen = b2.plen; req_valid = 1'b1;
    chip_data = b2.data;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check($sformatf("bp hold%0d", k), 64'({rsp_valid, rsp_data, req_ready, busy, chip_col}),
            64'({1'b1, 4'b0110, 1'b0, 1'b1, b.col}));
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("bp not_yet_accepted", 64'({req_ready, busy, chip_col}), 64'({1'b1, 1'b0, b.col}));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("bp accepted_after_rsp", 64'({req_ready, busy, chip_col, chip_row}),
          64'({1'b0, 1'b1, b2.col, b2.row}));
    watch(lat, pstart, pcnt, plast, mask, bad);
    check("bp2 latency", 64'(lat), 64'd8);
    check("bp2 rsp_data", 64'(rsp_data), 64'(b2.rdata));
    check("bp2 pulse", 64'({pstart[7:0], pcnt[7:0], mask}), 64'({8'd3, 8'd1, 4'b0001}));
    rsp_handshake("bp2");

    // Reset mid-pulse: ctrl pads drop immediately and the command is lost.
    b = '{2'b00, 5'd1, 5'd2, 4'b1111, 8'd200, 4'b1111, 0, 4'b0000, 0, 0, 4'b0000};
    issue_cmd(b, "rstp");
    repeat (10) @(negedge clk);
    check("rstp pulsing", 64'({cbl, cblen, csl, cwl}), 64'(4'b1111));
    rst_n = 1'b0;
    #1;
    check("rstp ctrl_async_low", 64'({cbl, cblen, csl, cwl}), 64'd0);
    check("rstp outputs_low", 64'({rsp_valid, busy, req_ready}), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    nrsp = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (rsp_valid || cbl || cblen || csl || cwl) nrsp++;
    end
    check("rstp no_response_or_pulse", 64'(nrsp), 64'd0);
    check("rstp idle_ready", 64'({req_ready, busy}), 64'({1'b1, 1'b0}));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
